// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types for the CPU / debug-loader memory port arbiter.
//   arb_state_t : arbiter FSM state (last grant owner, or debug lock).
//   arb_owner_t : which requester was granted most recently.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_OWN,
    ST_DBG_OWN,
    ST_DBG_LOCKED
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU,
    OWNER_DBG
  } arb_owner_t;

  // Width of the consecutive-contested-grant counter (MAX_HOLD <= 7).
  localparam int HOLD_W = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a single synchronous-read memory port between the CPU datapath
//   and a debug loader. Grants are combinational in the accepting cycle; read
//   data returns one cycle later on the requester that issued the read.
//
//   Ports
//     clock, reset                 : clock, synchronous active-high reset
//     cpu_req/we/addr/wdata        : CPU request (held until cpu_gnt)
//     cpu_gnt/stall/rvalid/rdata   : CPU grant, stall, read return
//     dbg_req/we/lock/addr/wdata   : debug request, dbg_lock keeps ownership
//     dbg_gnt/rvalid/rdata         : debug grant, read return
//     mem_we/addr/wdata, mem_rdata : memory port A (1-cycle read latency)
//
//   Build option
//     ARB_ROUND_ROBIN_EN : contention goes to the requester not granted last.
//     Undefined (default): CPU wins contention, except that after MAX_HOLD
//     consecutive contested CPU grants the debug loader gets one turn.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  logic       rd_pend_cpu, rd_pend_dbg;
  logic       contest, locked;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner;
`else
  logic [HOLD_W-1:0] hold, hold_nxt, hold_inc;
  logic              prev_dbg;
`endif

  assign contest = cpu_req & dbg_req;
  // Lock only binds while dbg_lock stays high; the first unlocked cycle is
  // arbitrated normally with the debug loader as previous owner.
  assign locked  = (state == ST_DBG_LOCKED) & dbg_lock;

  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    state_nxt = ST_IDLE;
    if (reset) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end else if (locked) begin
      dbg_gnt = dbg_req;
    end else if (contest) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_owner == OWNER_CPU) dbg_gnt = 1'b1;
      else                         cpu_gnt = 1'b1;
`else
      if (state == ST_CPU_OWN && hold == HOLD_W'(MAX_HOLD)) dbg_gnt = 1'b1;
      else                                                  cpu_gnt = 1'b1;
`endif
    end else begin
      cpu_gnt = cpu_req;
      dbg_gnt = dbg_req;
    end

    if (locked)       state_nxt = ST_DBG_LOCKED;
    else if (dbg_gnt) state_nxt = dbg_lock ? ST_DBG_LOCKED : ST_DBG_OWN;
    else if (cpu_gnt) state_nxt = ST_CPU_OWN;
    else              state_nxt = ST_IDLE;
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Counts consecutive contested grants won by the same requester. A grant
  // that changes ownership restarts the run at 1 (it is the first win of the
  // new owner), so the CPU gets exactly MAX_HOLD contested grants per turn.
  assign hold_inc = (hold == HOLD_W'(MAX_HOLD)) ? hold : hold + HOLD_W'(1);
  assign prev_dbg = (state == ST_DBG_OWN) | (state == ST_DBG_LOCKED);

  always_comb begin
    hold_nxt = '0;
    if (!contest)     hold_nxt = '0;
    else if (cpu_gnt) hold_nxt = (state == ST_CPU_OWN) ? hold_inc : HOLD_W'(1);
    else if (dbg_gnt) hold_nxt = prev_dbg ? hold_inc : HOLD_W'(1);
    else              hold_nxt = hold;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_pend_cpu <= 1'b0;
      rd_pend_dbg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner  <= OWNER_DBG;
`else
      hold        <= '0;
`endif
    end else begin
      state       <= state_nxt;
      rd_pend_cpu <= cpu_gnt & ~cpu_we;
      rd_pend_dbg <= dbg_gnt & ~dbg_we;
`ifdef ARB_ROUND_ROBIN_EN
      if (cpu_gnt)      last_owner <= OWNER_CPU;
      else if (dbg_gnt) last_owner <= OWNER_DBG;
`else
      hold        <= hold_nxt;
`endif
    end
  end

  // Memory port follows the granted requester; quiet when nobody is granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // A read pending from the previous cycle is dropped if reset is asserted
  // in its return cycle, so nothing escapes while reset is high.
  assign cpu_rvalid = rd_pend_cpu & ~reset;
  assign dbg_rvalid = rd_pend_dbg & ~reset;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  assign cpu_stall  = cpu_req & ~cpu_gnt & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios plus randomized traffic for mem_port_arbiter, checked
//   cycle by cycle against a behavioural model of the arbitration rules.
//   Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int MAX_HOLD = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: owner 0=none 1=cpu 2=dbg; streak = consecutive contested
  // wins by the current owner; last_g = last granted requester.
  int own, streak, last_g, g;
  bit lck, pc, pd;
  int cnt_c, cnt_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = 0; streak = 0; last_g = 2; lck = 1'b0; pc = 1'b0; pd = 1'b0;
  endtask

  // Called at posedge+1 after inputs are driven; samples mid-cycle.
  task automatic sample();
    logic             e_we;
    logic [31:0]      e_addr, e_wdata;
    #4;
    g = 0;
    if (!reset) begin
      if (lck && dbg_lock) g = dbg_req ? 2 : 0;
      else if (cpu_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        g = (last_g == 1) ? 2 : 1;
`else
        g = (own == 1 && streak == MAX_HOLD) ? 2 : 1;
`endif
      end
      else if (cpu_req) g = 1;
      else if (dbg_req) g = 2;
    end
    e_we    = (g == 1) ? cpu_we : (g == 2) ? dbg_we : 1'b0;
    e_addr  = (g == 1) ? 32'(cpu_addr)  : (g == 2) ? 32'(dbg_addr)  : 32'd0;
    e_wdata = (g == 1) ? 32'(cpu_wdata) : (g == 2) ? 32'(dbg_wdata) : 32'd0;
    chk("cpu_gnt",    cpu_gnt,   32'(g == 1));
    chk("dbg_gnt",    dbg_gnt,   32'(g == 2));
    chk("cpu_stall",  cpu_stall, 32'(cpu_req && !reset && g != 1));
    chk("mem_we",     mem_we,    32'(e_we));
    chk("mem_addr",   32'(mem_addr),  e_addr);
    chk("mem_wdata",  32'(mem_wdata), e_wdata);
    chk("cpu_rvalid", cpu_rvalid, 32'(pc && !reset));
    chk("dbg_rvalid", dbg_rvalid, 32'(pd && !reset));
    chk("cpu_rdata",  32'(cpu_rdata), (pc && !reset) ? 32'(mem_rdata) : 32'd0);
    chk("dbg_rdata",  32'(dbg_rdata), (pd && !reset) ? 32'(mem_rdata) : 32'd0);
    if (g == 1) cnt_c++;
    if (g == 2) cnt_d++;
  endtask

  // Commits the model for this cycle, then steps to posedge+1.
  task automatic advance();
    bit both, lck_n;
    int gg;
    gg = g;
    if (reset) model_reset();
    else begin
      both = cpu_req && dbg_req;
      if (!both)        streak = 0;
      else if (g == own) streak = (streak < MAX_HOLD) ? streak + 1 : streak;
      else              streak = 1;
      lck_n = (lck && dbg_lock) || (g == 2 && dbg_lock);
      own   = (g != 0) ? g : (lck_n ? 2 : 0);
      lck   = lck_n;
      if (g != 0) last_g = g;
      pc = (g == 1) && !cpu_we;
      pd = (g == 2) && !dbg_we;
    end
    @(posedge clock);
    #1;
    // A granted access completes; the requester drops it.
    if (gg == 1) cpu_req = 1'b0;
    if (gg == 2) dbg_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; sample(); advance(); reset = 1'b0;
  endtask

  task automatic drive_rand();
    reset = ($urandom_range(0, 59) == 0);
    if (!cpu_req && $urandom_range(0, 2) != 0) begin
      cpu_req = 1'b1; cpu_we = 1'($urandom);
      cpu_addr = ADDR_W'($urandom); cpu_wdata = DATA_W'($urandom);
    end
    if (!dbg_req && $urandom_range(0, 2) == 0) begin
      dbg_req = 1'b1; dbg_we = 1'($urandom);
      dbg_addr = ADDR_W'($urandom); dbg_wdata = DATA_W'($urandom);
    end
    if ($urandom_range(0, 7) == 0) dbg_lock = ~dbg_lock;
    mem_rdata = DATA_W'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b1; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = 16'hA5A5;
    model_reset();
    cnt_c = 0; cnt_d = 0;
    @(posedge clock); #1;

    // Reset dominates active requests.
    sample();
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_stall",   cpu_stall, 0);
    advance();
    reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    do_reset();

    // CPU read from idle, data back next cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005; mem_rdata = 16'h0000;
    sample();
    chk("r31_gnt",  cpu_gnt, 1);
    chk("r31_addr", 32'(mem_addr), 32'h005);
    advance();
    mem_rdata = 16'hBEEF;
    sample();
    chk("r31_rvalid", cpu_rvalid, 1);
    chk("r31_rdata",  32'(cpu_rdata), 32'hBEEF);
    chk("r31_dbgrv",  dbg_rvalid, 0);
    advance();

    // Continuous contention from reset.
    do_reset();
    cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < 10; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ADDR_W'(i); cpu_wdata = DATA_W'(i);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = ADDR_W'(i + 100); dbg_wdata = DATA_W'(i + 100);
      sample();
      advance();
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("contend_cpu_cnt", 32'(cnt_c), 5);
    chk("contend_dbg_cnt", 32'(cnt_d), 5);
`else
    chk("contend_cpu_cnt", 32'(cnt_c), 8);
    chk("contend_dbg_cnt", 32'(cnt_d), 2);
`endif
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Debug lock holds off a waiting CPU.
    do_reset();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 10'h3FF; dbg_wdata = 16'h1234;
    sample();
    chk("lock_dbg_gnt", dbg_gnt, 1);
    chk("lock_mem_we",  mem_we, 1);
    chk("lock_addr",    32'(mem_addr), 32'h3FF);
    chk("lock_wdata",   32'(mem_wdata), 32'h1234);
    advance();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h011;
    for (int i = 0; i < 2; i++) begin
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h3FF; dbg_wdata = 16'h1234;
      sample();
      chk("lock_cpu_gnt", cpu_gnt, 0);
      chk("lock_stall",   cpu_stall, 1);
      advance();
    end
    dbg_lock = 1'b0; dbg_req = 1'b1;
    sample();
    chk("unlock_cpu_gnt", cpu_gnt, 1);
    chk("unlock_dbg_gnt", dbg_gnt, 0);
    advance();
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Reset swallows a pending debug read.
    do_reset();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h007;
    sample();
    chk("rstrd_gnt", dbg_gnt, 1);
    advance();
    reset = 1'b1; mem_rdata = 16'h5555;
    sample();
    chk("rstrd_rvalid", dbg_rvalid, 0);
    chk("rstrd_rdata",  32'(dbg_rdata), 0);
    chk("rstrd_mem_we", mem_we, 0);
    advance();
    reset = 1'b0;
    sample();
    chk("rstrd_after", dbg_rvalid, 0);
    advance();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      sample();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width.
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 Parameter MAX_HOLD, default 4, consecutive contested grants before forced hand-over (range 1-7).
REQ-004 clock  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req / cpu_we  input  1 each  CPU datapath access request / write strobe.
REQ-007 cpu_addr  input  ADDR_W; cpu_wdata  input  DATA_W  CPU address, write data.
REQ-008 cpu_gnt / cpu_stall / cpu_rvalid  output  1 each  access accepted / request pending not granted / read data valid.
REQ-009 cpu_rdata  output  DATA_W  CPU read data.
REQ-010 dbg_req / dbg_we / dbg_lock  input  1 each  debug-loader request / write strobe / hold ownership.
REQ-011 dbg_addr  input  ADDR_W; dbg_wdata  input  DATA_W; dbg_gnt / dbg_rvalid  output  1; dbg_rdata  output  DATA_W.
REQ-012 mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W  memory port A, 1-cycle synchronous read.

Function
REQ-013 At most one of cpu_gnt, dbg_gnt SHALL be high per cycle; grant is combinational in the accepting cycle.
REQ-014 Requesters SHALL hold req/we/addr/wdata stable until gnt; a granted access completes in that cycle.
REQ-015 mem_addr/mem_wdata/mem_we SHALL mirror the granted requester; with no grant, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-016 A granted read SHALL raise only that requester's rvalid exactly one cycle later with rdata=mem_rdata; rdata=0 when rvalid low; writes produce no rvalid.
REQ-017 cpu_stall SHALL equal cpu_req AND NOT cpu_gnt.
REQ-018 FSM states IDLE, CPU_OWN, DBG_OWN, DBG_LOCKED; state reflects last grant owner (IDLE after a cycle with no grant).
REQ-019 Uncontested request SHALL be granted same cycle from IDLE, CPU_OWN, DBG_OWN.
REQ-020 Contention (default policy): CPU wins, unless hold counter equals MAX_HOLD with CPU as owner, then DBG wins.
REQ-021 Hold counter (3 bits) SHALL increment per contested grant to the current owner, clear on owner change or any cycle the other requester is idle, saturate at MAX_HOLD.
REQ-022 DBG grant with dbg_lock=1 SHALL enter DBG_LOCKED; in DBG_LOCKED cpu_gnt=0, dbg_gnt=dbg_req; exit to DBG_OWN on first cycle dbg_lock=0 (CPU arbitrable that cycle).
REQ-023 A read pending for rvalid SHALL complete even if ownership changes the next cycle.

Reset
REQ-024 reset SHALL take priority over all inputs in the same cycle.
REQ-025 On reset: state IDLE, hold counter 0, last_owner DBG, pending-read flags 0; all gnt/rvalid/stall/mem_we 0, rdata 0.
REQ-026 Reset asserted during a pending read SHALL discard it; no rvalid after reset.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: contention grants the requester not granted last (last_owner), hold counter unused; DBG_LOCKED unchanged.
REQ-028 Macro undefined: fixed CPU priority with MAX_HOLD starvation guard per REQ-020/021.

Structure
REQ-029 Package constants SHALL hold arb_state_t (4-state enum) and arb_owner_t (CPU, DBG).
REQ-030 Single module, no sub-modules; hold counter and rvalid pipeline inline.

Verification
REQ-031 Reset, then cpu read addr 0x005, mem_rdata=0xBEEF -> cpu_gnt same cycle, cpu_rvalid=1, cpu_rdata=0xBEEF next cycle, dbg_rvalid=0.
REQ-032 Both req continuously, default build, MAX_HOLD=4 -> 4 cpu_gnt, 1 dbg_gnt, repeat; stall high on waiting CPU cycles.
REQ-033 ARB_ROUND_ROBIN_EN, both req continuously -> grants alternate CPU, DBG, CPU from reset.
REQ-034 dbg write 0x3FF=0x1234 with dbg_lock=1 for 3 cycles while cpu_req=1 -> cpu_gnt=0 during lock, mem_we=1 mem_addr=0x3FF; cpu_gnt on first unlocked contest.
REQ-035 Granted dbg read, reset next cycle -> dbg_rvalid stays 0, all outputs 0, state IDLE.
